// File: rtl/spi_cfg_master.sv
// Two-requester SPI configuration master: round-robin arbitration between ports A and B,
// each granted write sent as one 16-bit mode-0 frame {1'b1, addr[6:0], data[7:0]}, MSB first.
module spi_cfg_master #(
    parameter int unsigned CLK_DIV  = 5,
    parameter int unsigned IDLE_GAP = 4,
    parameter int unsigned MAX_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [6:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [6:0] b_addr,
    input  logic [7:0] b_data,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GapW = $clog2(IDLE_GAP + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(IDLE_GAP - 1);
    localparam logic [6:0]      MaxAddr = 7'(MAX_ADDR);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_t;

    state_t          state;
    logic            last_b;
    logic [14:0]     shreg;
    logic [DivW-1:0] div_cnt;
    logic [3:0]      bit_cnt;
    logic [GapW-1:0] gap_cnt;

    logic       grant_a;
    logic       grant_b;
    logic       handshake;
    logic [6:0] sel_addr;
    logic [7:0] sel_data;
    logic       addr_ok;
    logic       div_last;

    // Ties go to whichever requester was not served last.
    always_comb begin
        grant_a   = a_valid && (!b_valid || last_b);
        grant_b   = b_valid && !grant_a;
        a_ready   = (state == StIdle) && grant_a;
        b_ready   = (state == StIdle) && grant_b;
        handshake = a_ready || b_ready;
        sel_addr  = grant_a ? a_addr : b_addr;
        sel_data  = grant_a ? a_data : b_data;
        addr_ok   = (sel_addr <= MaxAddr);
        div_last  = (div_cnt == DivLast);
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            last_b  <= 1'b1;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            nCS     <= 1'b1;
            SCLK    <= 1'b0;
            COPI    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (handshake) begin
                        last_b <= grant_b;
                        if (addr_ok) begin
                            // Bit 15 (write flag) goes straight to COPI; shreg holds bits 14:0.
                            shreg   <= {sel_addr, sel_data};
                            COPI    <= 1'b1;
                            nCS     <= 1'b0;
                            SCLK    <= 1'b0;
                            div_cnt <= '0;
                            bit_cnt <= '0;
                            state   <= StSetup;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        SCLK    <= 1'b1;
                        state   <= StShift;
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end
                StShift: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        if (SCLK) begin
                            // Falling edge: present the next bit; zeros follow the last bit.
                            SCLK  <= 1'b0;
                            COPI  <= shreg[14];
                            shreg <= {shreg[13:0], 1'b0};
                        end else if (bit_cnt == 4'd15) begin
                            state <= StHold;
                        end else begin
                            SCLK    <= 1'b1;
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end
                StHold: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        gap_cnt <= '0;
                        nCS     <= 1'b1;
                        done    <= 1'b1;
                        state   <= StGap;
                    end else begin
                        div_cnt <= div_cnt + DivW'(1);
                    end
                end
                StGap: begin
                    if (gap_cnt == GapLast) begin
                        state <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + GapW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master with a behavioural SPI register peripheral
// (regs 0 = en_out, 2 = en_pwm, 4 = duty) that only accepts exact 16-bit write frames.
module tb_spi_cfg_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_valid = 1'b0;
    logic [6:0] a_addr = '0;
    logic [7:0] a_data = '0;
    logic       b_valid = 1'b0;
    logic [6:0] b_addr = '0;
    logic [7:0] b_data = '0;
    logic       a_ready, b_ready;
    logic       nCS, SCLK, COPI, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #50 clk = ~clk;

    spi_cfg_master #(
        .CLK_DIV (5),
        .IDLE_GAP(4),
        .MAX_ADDR(4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_addr (a_addr),
        .a_data (a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_addr (b_addr),
        .b_data (b_data),
        .nCS    (nCS),
        .SCLK   (SCLK),
        .COPI   (COPI),
        .busy   (busy),
        .done   (done),
        .err    (err)
    );

    // Peripheral model: shift COPI on SCLK rise, commit on nCS rise if exactly 16 bits.
    logic [15:0] rx_sh = '0;
    logic [15:0] rx_frame = '0;
    int          rx_cnt = 0;
    int          rx_frames = 0;
    logic [7:0]  regs [0:7];
    logic        per_clr = 1'b0;

    always @(posedge SCLK or negedge nCS) begin
        if (SCLK) begin
            if (!nCS) begin
                rx_sh = {rx_sh[14:0], COPI};
                rx_cnt++;
            end
        end else begin
            rx_sh  = '0;
            rx_cnt = 0;
        end
    end

    always @(posedge nCS or posedge per_clr) begin
        if (per_clr) begin
            for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        end else if (rx_cnt == 16 && rx_sh[15]) begin
            if (rx_sh[14:11] == 4'd0) regs[rx_sh[10:8]] = rx_sh[7:0];
            rx_frame = rx_sh;
            rx_frames++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_regs();
        per_clr = 1'b1;
        #1;
        per_clr = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (a_ready || b_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Counts nCS-low cycles and done pulses until busy drops.
    task automatic wait_idle(output int low, output int dones, output bit ok);
        low   = 0;
        dones = 0;
        ok    = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (!nCS) low++;
            if (done) dones++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(input bit use_b, input logic [6:0] addr, input logic [7:0] data,
                            output int low, output int dones);
        bit ok;
        if (use_b) begin
            b_addr = addr; b_data = data; b_valid = 1'b1;
        end else begin
            a_addr = addr; a_data = data; a_valid = 1'b1;
        end
        #1;
        wait_ready(ok);
        check("wr_ready_seen", 32'(ok), 1);
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_idle(low, dones, ok);
        check("wr_idle_seen", 32'(ok), 1);
    endtask

    initial begin
        int low, dones, n0, high, nbusy, rdyb;
        bit ok, seen;
        logic [15:0] frames [0:3];
        frames[0] = 16'h8111; frames[1] = 16'h8222;
        frames[2] = 16'h8333; frames[3] = 16'h8444;

        clear_regs();
        tick();
        // Reset values while rst_n is held low.
        check("rst_ncs", 32'(nCS), 1);
        check("rst_sclk", 32'(SCLK), 0);
        check("rst_copi", 32'(COPI), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Single write from A: frame 0x80A5, 170 cycles of nCS low, one done.
        do_write(1'b0, 7'h00, 8'hA5, low, dones);
        check("t1_ncs_low", 32'(low), 170);
        check("t1_done_cnt", 32'(dones), 1);
        check("t1_frame", 32'(rx_frame), 32'h80A5);
        check("t1_bits", 32'(rx_cnt), 16);
        check("t1_frames", 32'(rx_frames), 1);
        check("t1_reg0", 32'(regs[0]), 32'hA5);

        // Both requesters held valid: grants alternate A, B, A, B.
        do_reset();
        n0 = rx_frames;
        a_addr = 7'h01; a_data = 8'h11;
        b_addr = 7'h02; b_data = 8'h22;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            wait_ready(ok);
            check("rr_ready_seen", 32'(ok), 1);
            check("rr_grant_b", 32'(b_ready), i % 2);
            check("rr_grant_a", 32'(a_ready), 1 - (i % 2));
            if (i > 0) check("rr_frame", 32'(rx_frame), 32'(frames[i-1]));
            tick();
            if (i % 2 == 1) begin b_addr = 7'h04; b_data = 8'h44; end
            else begin a_addr = 7'h03; a_data = 8'h33; end
            if (i == 3) begin a_valid = 1'b0; b_valid = 1'b0; end
        end
        wait_idle(low, dones, ok);
        check("rr_idle_seen", 32'(ok), 1);
        check("rr_last_frame", 32'(rx_frame), 32'h8444);
        check("rr_frame_cnt", 32'(rx_frames - n0), 4);

        // Out-of-range address from B: accepted, err pulse, no frame.
        do_reset();
        n0 = rx_frames;
        b_addr = 7'h05; b_data = 8'h12; b_valid = 1'b1;
        #1;
        check("bad_b_ready", 32'(b_ready), 1);
        check("bad_a_ready", 32'(a_ready), 0);
        tick();
        b_valid = 1'b0;
        check("bad_err_pulse", 32'(err), 1);
        check("bad_ncs", 32'(nCS), 1);
        check("bad_busy", 32'(busy), 0);
        tick();
        check("bad_err_clear", 32'(err), 0);
        low = 0; dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (!nCS) low++;
            if (done) dones++;
            tick();
        end
        check("bad_ncs_low", 32'(low), 0);
        check("bad_done", 32'(dones), 0);
        check("bad_frames", 32'(rx_frames - n0), 0);

        // Reset during bit 7 abandons the frame; a following write completes.
        do_reset();
        clear_regs();
        tick();
        n0 = rx_frames;
        a_addr = 7'h04; a_data = 8'h55; a_valid = 1'b1;
        #1;
        wait_ready(ok);
        check("mid_ready_seen", 32'(ok), 1);
        tick();
        a_valid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (rx_cnt == 7) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("mid_bit7_seen", 32'(ok), 1);
        rst_n = 1'b0;
        #1;
        check("mid_ncs", 32'(nCS), 1);
        check("mid_sclk", 32'(SCLK), 0);
        check("mid_copi", 32'(COPI), 0);
        check("mid_busy", 32'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_frames", 32'(rx_frames - n0), 0);
        check("mid_duty_untouched", 32'(regs[4]), 0);
        do_write(1'b0, 7'h04, 8'h80, low, dones);
        check("mid_after_low", 32'(low), 170);
        check("mid_after_done", 32'(dones), 1);
        check("mid_duty", 32'(regs[4]), 32'h80);

        // Back-to-back: A stays valid with new data; gap is IDLE_GAP + 1 cycles.
        do_reset();
        a_addr = 7'h01; a_data = 8'h01; a_valid = 1'b1;
        #1;
        check("b2b_ready", 32'(a_ready), 1);
        tick();
        a_data = 8'h02;
        seen = 1'b0; ok = 1'b0; high = 0; nbusy = 0; rdyb = 0;
        for (int n = 0; n < 1000; n++) begin
            if (busy && a_ready) rdyb++;
            if (!seen && nCS) seen = 1'b1;
            if (seen) begin
                if (!nCS) begin
                    ok = 1'b1;
                    break;
                end
                high++;
                if (!busy) nbusy++;
            end
            tick();
        end
        a_valid = 1'b0;
        check("b2b_second_start", 32'(ok), 1);
        check("b2b_ncs_high", 32'(high), 5);
        check("b2b_busy_low", 32'(nbusy), 1);
        check("b2b_ready_busy", 32'(rdyb), 0);
        wait_idle(low, dones, ok);
        check("b2b_idle_seen", 32'(ok), 1);
        check("b2b_low", 32'(low), 170);
        check("b2b_frame", 32'(rx_frame), 32'h8102);

        // End-to-end register programming.
        do_reset();
        clear_regs();
        tick();
        do_write(1'b0, 7'h00, 8'hFF, low, dones);
        do_write(1'b1, 7'h02, 8'h0F, low, dones);
        do_write(1'b0, 7'h04, 8'h40, low, dones);
        check("e2e_en_out", 32'(regs[0]), 32'hFF);
        check("e2e_reg1", 32'(regs[1]), 0);
        check("e2e_en_pwm", 32'(regs[2]), 32'h0F);
        check("e2e_reg3", 32'(regs[3]), 0);
        check("e2e_duty", 32'(regs[4]), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
